if_id_queue: RTL and testbench

Parametrised IF→ID instruction queue that replaces the fixed two-instruction IF/ID pipeline register. It buffers up to DEPTH fetched instructions, each with its own PC. Fetch can deliver 0..LANES instructions per cycle, and decode can consume 0..LANES per cycle, so partial issue no longer stalls the whole fetch group. It sits between the fetch stage and the decode/dispatch stage and supports a front-end flush.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_id_queue_popcount_contig.sv | 26 ++
 rtl/if_id_queue.sv | 120 ++++++++++++
 tb/tb_if_id_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared front-end types and constants.
// Used by the IF->ID instruction queue.
package fetch_pkg;

  localparam int FQ_XLEN = 32;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/if_id_queue_popcount_contig.sv
// Contiguous lane-mask to lane count.
// Flags masks with holes in simulation.
module popcount_contig #(
  parameter int LANES = 2,
  parameter int NW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] mask,
  output logic [NW-1:0]    n
);

  logic contig;

  // Count set lanes and confirm no set lane follows a clear one.
  always_comb begin
    n      = '0;
    contig = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      n = n + NW'(mask[i]);
      if (i > 0 && mask[i] && !mask[i-1])
        contig = 1'b0;
    end
    assert (contig)
      else $error("enq_mask is not contiguous from lane 0");
  end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: a circular buffer
// of {pc, instr} with multi-lane enq and deq.
module if_id_queue
  import fetch_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int NW    = $clog2(LANES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  logic [LANES-1:0]      enq_mask,
  input  logic [XLEN-1:0]       enq_pc,
  input  logic [LANES*XLEN-1:0] enq_instr,
  output logic                  enq_ready,
  output logic [LANES-1:0]      deq_valid,
  output logic [LANES*XLEN-1:0] deq_pc,
  output logic [LANES*XLEN-1:0] deq_instr,
  input  logic [NW-1:0]         deq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [NW-1:0] enq_n;
  logic [CW-1:0] enq_add;
  logic [CW-1:0] deq_n;
  logic [CW-1:0] deq_req;
  logic          enq_fire;
  fq_entry_t     wr_ent [LANES];

  popcount_contig #(
    .LANES (LANES),
    .NW    (NW)
  ) u_popcnt (
    .mask (enq_mask),
    .n    (enq_n)
  );

  // Readiness uses current occupancy only; no same-cycle drain credit.
  always_comb begin
    enq_ready = (count_q <= CW'(DEPTH - LANES));
    enq_fire  = enq_valid && enq_ready && !flush;
    enq_add   = enq_fire ? CW'(enq_n) : '0;
    deq_req   = CW'(deq_count);
    deq_n     = (deq_req > count_q) ? count_q : deq_req;
  end

  // Next pointer and occupancy; flush wins over both enq and deq.
  always_comb begin
    head_d  = head_q + PW'(deq_n);
    tail_d  = tail_q + PW'(enq_add);
    count_d = count_q + enq_add - deq_n;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Per-lane write entries; lane i PC is the group PC plus 4*i.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wr_ent[i].pc    = FQ_XLEN'(enq_pc + XLEN'(4 * i));
      wr_ent[i].instr = FQ_XLEN'(enq_instr[i*XLEN +: XLEN]);
    end
  end

  // Storage is not reset; only lanes below enq_n are written.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (NW'(i) < enq_n)
          mem_q[tail_q + PW'(i)] <= wr_ent[i];
      end
    end
  end

  // Oldest entries on output lanes; empty lanes show pc 0 and NOP.
  always_comb begin
    deq_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      deq_pc[i*XLEN +: XLEN]    = '0;
      deq_instr[i*XLEN +: XLEN] = XLEN'(NOP);
      if (CW'(i) < count_q) begin
        deq_valid[i]              = 1'b1;
        deq_pc[i*XLEN +: XLEN]    = XLEN'(mem_q[head_q + PW'(i)].pc);
        deq_instr[i*XLEN +: XLEN] = XLEN'(mem_q[head_q + PW'(i)].instr);
      end
    end
  end

  // Decode may never consume more than is queued.
  assert property (@(posedge clk) disable iff (reset || flush)
    deq_req <= count_q)
    else $error("deq_count exceeds queue occupancy");

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table,
// scoreboard and multi-cycle sequences.
module tb_if_id_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOPV = 32'h00000013;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  enq_valid;
  logic [LANES-1:0]      enq_mask;
  logic [XLEN-1:0]       enq_pc;
  logic [LANES*XLEN-1:0] enq_instr;
  logic                  enq_ready;
  logic [LANES-1:0]      deq_valid;
  logic [LANES*XLEN-1:0] deq_pc;
  logic [LANES*XLEN-1:0] deq_instr;
  logic [1:0]            deq_count;

  if_id_queue #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_mask  (enq_mask),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .deq_count (deq_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          fl;
    bit          ev;
    logic [1:0]  m;
    logic [31:0] pc;
    int          dc;
    bit          x_rdy;
    logic [1:0]  x_val;
    logic [31:0] x_pc0;
  } vec_t;

  ent_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  bit          track    = 0;
  logic [31:0] last_pc;
  vec_t        vt [13];

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < LANES; i++) begin
      if (i < sb.size()) begin
        chk(deq_valid[i] === 1'b1, "lane_valid", 64'(deq_valid[i]), 64'd1);
        chk(deq_pc[i*32 +: 32] === sb[i].pc, "lane_pc",
            64'(deq_pc[i*32 +: 32]), 64'(sb[i].pc));
        chk(deq_instr[i*32 +: 32] === sb[i].instr, "lane_instr",
            64'(deq_instr[i*32 +: 32]), 64'(sb[i].instr));
      end else begin
        chk(deq_valid[i] === 1'b0 && deq_pc[i*32 +: 32] === 32'd0
            && deq_instr[i*32 +: 32] === NOPV, "lane_empty",
            {deq_pc[i*32 +: 32], deq_instr[i*32 +: 32]}, {32'd0, NOPV});
      end
    end
    chk(enq_ready === (sb.size() <= DEPTH - LANES), "enq_ready",
        64'(enq_ready), 64'(sb.size() <= DEPTH - LANES));
  endtask

  task automatic step(input bit fl, input bit ev, input logic [1:0] m,
                      input logic [31:0] pc, input int dc);
    bit          rdy;
    logic [31:0] ins [LANES];
    int          ndc;
    check_outputs();
    rdy = (sb.size() <= DEPTH - LANES);
    ndc = (dc > sb.size()) ? sb.size() : dc;
    if (track && !fl) begin
      for (int k = 0; k < ndc; k++) begin
        chk(deq_pc[k*32 +: 32] === last_pc + 32'd4, "pc_seq",
            64'(deq_pc[k*32 +: 32]), 64'(last_pc + 32'd4));
        last_pc = last_pc + 32'd4;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      ins[i] = $urandom;
      enq_instr[i*32 +: 32] = ins[i];
    end
    flush     = fl;
    enq_valid = ev;
    enq_mask  = m;
    enq_pc    = pc;
    deq_count = 2'(dc);
    if (fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < ndc; k++) void'(sb.pop_front());
      if (ev && rdy) begin
        for (int i = 0; i < LANES; i++)
          if (m[i]) sb.push_back({pc + 32'(4 * i), ins[i]});
      end
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_count = 2'd0;
  endtask

  initial begin
    vt[0]  = '{0, 1, 2'b11, 32'h100, 0, 1, 2'b11, 32'h100};
    vt[1]  = '{0, 1, 2'b11, 32'h108, 0, 1, 2'b11, 32'h100};
    vt[2]  = '{0, 1, 2'b11, 32'h110, 0, 1, 2'b11, 32'h100};
    vt[3]  = '{0, 1, 2'b11, 32'h118, 0, 0, 2'b11, 32'h100};
    vt[4]  = '{0, 1, 2'b11, 32'h120, 0, 0, 2'b11, 32'h100};
    vt[5]  = '{0, 0, 2'b00, 32'h000, 1, 0, 2'b11, 32'h104};
    vt[6]  = '{0, 1, 2'b11, 32'h200, 2, 1, 2'b11, 32'h10C};
    vt[7]  = '{1, 1, 2'b11, 32'h500, 2, 1, 2'b00, 32'h000};
    vt[8]  = '{0, 1, 2'b01, 32'h200, 0, 1, 2'b01, 32'h200};
    vt[9]  = '{0, 1, 2'b11, 32'h300, 0, 1, 2'b11, 32'h200};
    vt[10] = '{0, 0, 2'b00, 32'h000, 1, 1, 2'b11, 32'h300};
    vt[11] = '{0, 0, 2'b00, 32'h000, 2, 1, 2'b00, 32'h000};
    vt[12] = '{0, 1, 2'b00, 32'h700, 0, 1, 2'b00, 32'h000};

    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_mask  = '0;
    enq_pc    = '0;
    enq_instr = '0;
    deq_count = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      step(vt[v].fl, vt[v].ev, vt[v].m, vt[v].pc, vt[v].dc);
      chk(enq_ready === vt[v].x_rdy, "vec_ready",
          64'(enq_ready), 64'(vt[v].x_rdy));
      chk(deq_valid === vt[v].x_val, "vec_valid",
          64'(deq_valid), 64'(vt[v].x_val));
      chk(deq_pc[31:0] === vt[v].x_pc0, "vec_pc0",
          64'(deq_pc[31:0]), 64'(vt[v].x_pc0));
    end

    step(0, 1, 2'b11, 32'h600, 0);
    step(0, 1, 2'b11, 32'h608, 0);
    step(0, 1, 2'b11, 32'h610, 0);
    step(1, 1, 2'b11, 32'h780, 2);
    chk(deq_valid === 2'b00, "flush_valid", 64'(deq_valid), 64'd0);
    chk(enq_ready === 1'b1, "flush_ready", 64'(enq_ready), 64'd1);
    step(0, 1, 2'b11, 32'h400, 0);
    chk(deq_valid === 2'b11 && deq_pc[31:0] === 32'h400, "after_flush",
        {30'd0, deq_valid, deq_pc[31:0]}, {30'd0, 2'b11, 32'h400});
    step(1, 0, 2'b00, 32'h0, 0);

    begin
      logic [31:0] npc;
      npc     = 32'h1000;
      last_pc = 32'h0FFC;
      track   = 1;
      for (int c = 0; c < 30; c++) begin
        bit r;
        r = (sb.size() <= DEPTH - LANES);
        step(0, 1, 2'b11, npc, (sb.size() > 0) ? 1 : 0);
        if (r) npc = npc + 32'd8;
      end
      for (int c = 0; c < 8 && sb.size() > 0; c++)
        step(0, 0, 2'b00, 32'h0, (sb.size() >= 2) ? 2 : 1);
      chk(last_pc === npc - 32'd4, "wrap_drain",
          64'(last_pc), 64'(npc - 32'd4));
      track = 0;
    end

    step(0, 1, 2'b11, 32'h800, 0);
    step(0, 1, 2'b11, 32'h808, 0);
    step(0, 1, 2'b01, 32'h810, 0);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk(enq_ready === 1'b1, "rst_ready", 64'(enq_ready), 64'd1);
    chk(deq_valid === 2'b00, "rst_valid", 64'(deq_valid), 64'd0);
    chk(deq_pc === 64'd0, "rst_pc", deq_pc, 64'd0);
    chk(deq_instr === {NOPV, NOPV}, "rst_instr", deq_instr, {NOPV, NOPV});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 2'b11, 32'h900, 0);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
